line_resp_slave: RTL and testbench

LINE_RESP_SLAVE -- requirements
Module: line_resp_slave

---
 rtl/line_resp_slave_pkg.sv | 23 ++
 rtl/line_resp_ram.sv | 40 ++++
 rtl/line_resp_slave.sv | 191 +++++++++++++++++++
 tb/tb_line_resp_slave.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_resp_slave_pkg.sv
// Shared constants, FSM encoding and beat-address helper for line_resp_slave.
// Lines are 16 words (64 bytes); bursts wrap within the line.
package line_resp_slave_pkg;

    localparam int unsigned LINE_WORDS = 16;
    localparam int unsigned BEAT_W     = 4;
    localparam int unsigned CNT_W      = 3;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRdWait  = 3'd1,
        StRdBurst = 3'd2,
        StWrData  = 3'd3,
        StWrResp  = 3'd4
    } state_e;

    // Word index inside the line for beat n of a burst starting at word offset start.
    function automatic logic [BEAT_W-1:0] wrap_idx(input logic [BEAT_W-1:0] start,
                                                   input logic [BEAT_W-1:0] beat);
        return start + beat;
    endfunction

endpackage

// File: rtl/line_resp_ram.sv
// Single-port word store: 1-cycle synchronous read, per-byte write enables.
// Only the read-data register is reset; array contents survive reset.
module line_resp_ram #(
    parameter int unsigned MEM_AW = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [MEM_AW-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem [2**MEM_AW];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // rdata_q only updates on a read, so it holds the current beat while stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/line_resp_slave.sv
// Line-wrapping burst slave: 16-beat wrapped reads, wlast-terminated wrapped writes.
// Optional LINE_RESP_STALL_EN inserts one idle cycle after every completed read beat.
module line_resp_slave
    import line_resp_slave_pkg::*;
#(
    parameter int unsigned MEM_AW = 10,
    parameter int unsigned RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic        s_rlast,
    output logic        s_rvalid,
    input  logic        s_rready,
    input  logic [31:0] s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wlast,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic        s_bvalid,
    input  logic        s_bready
);

    localparam int unsigned LineAw = MEM_AW - BEAT_W;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LineAw-1:0]   line_q, line_d;
    logic [BEAT_W-1:0]   off_q, off_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                rvalid_q, rvalid_d;

    logic [BEAT_W-1:0]   beat_nxt;
    logic                ar_hs, aw_hs, r_hs, w_hs;
    logic                ram_en, ram_we;
    logic [3:0]          ram_be;
    logic [MEM_AW-1:0]   ram_addr;
    logic [31:0]         ram_rdata;

    // Address bits above the store and the byte offset are deliberately ignored.
    logic unused_addr;
    assign unused_addr = ^{s_araddr[31:MEM_AW+2], s_araddr[1:0],
                           s_awaddr[31:MEM_AW+2], s_awaddr[1:0]};

    assign s_arready = (state_q == StIdle);
    assign s_awready = (state_q == StIdle) & ~s_arvalid;
    assign s_wready  = (state_q == StWrData);
    assign s_bvalid  = (state_q == StWrResp);
    assign s_rvalid  = rvalid_q;
    assign s_rlast   = rvalid_q & (beat_q == BEAT_W'(LINE_WORDS - 1));
    assign s_rdata   = ram_rdata;

    assign ar_hs    = s_arvalid & s_arready;
    assign aw_hs    = s_awvalid & s_awready;
    assign r_hs     = s_rvalid & s_rready;
    assign w_hs     = s_wvalid & s_wready;
    assign beat_nxt = beat_q + BEAT_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        line_d   = line_q;
        off_d    = off_q;
        beat_d   = beat_q;
        rvalid_d = rvalid_q;
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_be   = 4'h0;
        ram_addr = {line_q, wrap_idx(off_q, beat_q)};

        unique case (state_q)
            StIdle: begin
                if (ar_hs) begin
                    line_d   = s_araddr[MEM_AW+1:BEAT_W+2];
                    off_d    = s_araddr[BEAT_W+1:2];
                    beat_d   = '0;
                    // Beat 0 is fetched now and held in the RAM output until presented.
                    ram_en   = 1'b1;
                    ram_addr = s_araddr[MEM_AW+1:2];
                    if (RD_LAT > 1) begin
                        state_d = StRdWait;
                        cnt_d   = CNT_W'(RD_LAT - 1);
                    end else begin
                        state_d  = StRdBurst;
                        rvalid_d = 1'b1;
                    end
                end else if (aw_hs) begin
                    line_d  = s_awaddr[MEM_AW+1:BEAT_W+2];
                    off_d   = s_awaddr[BEAT_W+1:2];
                    beat_d  = '0;
                    state_d = StWrData;
                end
            end

            StRdWait: begin
                // Leave on the edge where the counter reaches zero so rvalid lands at RD_LAT.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d    = '0;
                    state_d  = StRdBurst;
                    rvalid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            StRdBurst: begin
                if (r_hs) begin
                    if (beat_q == BEAT_W'(LINE_WORDS - 1)) begin
                        state_d  = StIdle;
                        rvalid_d = 1'b0;
                        beat_d   = '0;
                    end else begin
                        beat_d   = beat_nxt;
                        ram_en   = 1'b1;
                        ram_addr = {line_q, wrap_idx(off_q, beat_nxt)};
`ifdef LINE_RESP_STALL_EN
                        rvalid_d = 1'b0;
`endif
                    end
                end
`ifdef LINE_RESP_STALL_EN
                else if (!rvalid_q) begin
                    rvalid_d = 1'b1;
                end
`endif
            end

            StWrData: begin
                if (w_hs) begin
                    ram_en = 1'b1;
                    ram_we = 1'b1;
                    ram_be = s_wstrb;
                    beat_d = beat_nxt;
                    if (s_wlast) begin
                        state_d = StWrResp;
                        beat_d  = '0;
                    end
                end
            end

            StWrResp: begin
                if (s_bready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d  = StIdle;
                rvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            line_q   <= '0;
            off_q    <= '0;
            beat_q   <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            line_q   <= line_d;
            off_q    <= off_d;
            beat_q   <= beat_d;
            rvalid_q <= rvalid_d;
        end
    end

    line_resp_ram #(
        .MEM_AW (MEM_AW)
    ) u_ram (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (ram_en & ~rst),
        .we_i    (ram_we),
        .be_i    (ram_be),
        .addr_i  (ram_addr),
        .wdata_i (s_wdata),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_line_resp_slave.sv
// Randomized bench for line_resp_slave against a word-array model of the line store.
module tb_line_resp_slave;

    localparam int unsigned MEM_AW = 10;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned DEPTH  = 2**MEM_AW;
`ifdef LINE_RESP_STALL_EN
    localparam int unsigned BEAT_GAP = 2;
`else
    localparam int unsigned BEAT_GAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic        s_rlast;
    logic        s_rvalid;
    logic        s_rready;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wlast;
    logic        s_wvalid;
    logic        s_wready;
    logic        s_bvalid;
    logic        s_bready;

    int vectors     = 0;
    int miscompares = 0;
    int aw_leak     = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] wd [32];
    logic [3:0]  ws [32];

    always #5 clk = ~clk;

    line_resp_slave #(
        .MEM_AW (MEM_AW),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rlast   (s_rlast),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wlast   (s_wlast),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Store word index touched by beat n of a burst starting at byte address addr.
    function automatic int unsigned beat_word(input logic [31:0] addr, input int unsigned n);
        int unsigned wa;
        wa = int'(addr >> 2);
        return ((wa & ~32'hF) + ((wa + n) & 32'hF)) % DEPTH;
    endfunction

    task automatic rd_burst(input logic [31:0] addr, input bit rnd_ready, input bit chk_timing,
                            input int abort_at);
        int guard;
        int beat;
        int cyc;
        int first;
        bit rr;
        s_araddr  = addr;
        s_arvalid = 1'b1;
        #1;
        guard = 0;
        while (!s_arready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("ar_accept", 32'(s_arready), 32'd1);
        @(posedge clk);
        beat  = 0;
        cyc   = 0;
        first = -1;
        while (beat < 16 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            s_arvalid = 1'b0;
            if (s_awready) aw_leak++;
            if (s_rvalid) begin
                if (first < 0) first = cyc;
                check("rdata", s_rdata, model[beat_word(addr, beat)]);
                check("rlast", 32'(s_rlast), 32'(beat == 15));
                if (beat == abort_at) begin
                    rst      = 1'b1;
                    s_rready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    rst      = 1'b0;
                    s_rready = 1'b0;
                    check("abort_rvalid", 32'(s_rvalid), 32'd0);
                    check("abort_rlast", 32'(s_rlast), 32'd0);
                    check("abort_rdata", s_rdata, 32'd0);
                    check("abort_idle", 32'(s_arready), 32'd1);
                    check("abort_bvalid", 32'(s_bvalid), 32'd0);
                    return;
                end
            end
            rr       = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            s_rready = rr;
            if (s_rvalid && rr) beat++;
        end
        check("rd_beats", 32'(beat), 32'd16);
        if (chk_timing) begin
            check("rd_latency", 32'(first), 32'(RD_LAT));
            check("rd_last_cycle", 32'(cyc), 32'(RD_LAT + 15 * BEAT_GAP));
        end
        @(negedge clk);
        s_rready = 1'b0;
        check("rd_done", 32'(s_rvalid), 32'd0);
    endtask

    task automatic wr_burst(input logic [31:0] addr, input int nb, input bit rnd_valid,
                            input int bdelay);
        int guard;
        int n;
        s_awaddr  = addr;
        s_awvalid = 1'b1;
        #1;
        guard = 0;
        while (!s_awready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("aw_accept", 32'(s_awready), 32'd1);
        @(posedge clk);
        n     = 0;
        guard = 0;
        while (n < nb && guard < 1000) begin
            @(negedge clk);
            guard++;
            s_awvalid = 1'b0;
            s_wvalid  = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_wdata   = wd[n];
            s_wstrb   = ws[n];
            s_wlast   = (n == nb - 1);
            if (s_wvalid && s_wready) begin
                for (int b = 0; b < 4; b++) begin
                    if (ws[n][b]) model[beat_word(addr, n)][8*b +: 8] = wd[n][8*b +: 8];
                end
                n++;
            end
        end
        check("wr_beats", 32'(n), 32'(nb));
        for (int k = 0; k <= bdelay; k++) begin
            @(negedge clk);
            s_wvalid = 1'b0;
            s_wlast  = 1'b0;
            check("bvalid_hold", 32'(s_bvalid), 32'd1);
            check("wready_resp", 32'(s_wready), 32'd0);
            s_bready = (k == bdelay);
        end
        @(negedge clk);
        s_bready = 1'b0;
        check("bvalid_clr", 32'(s_bvalid), 32'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
        rst       = 1'b1;
        s_araddr  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        s_awaddr  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wlast   = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rvalid", 32'(s_rvalid), 32'd0);
        check("rst_rlast", 32'(s_rlast), 32'd0);
        check("rst_rdata", s_rdata, 32'd0);
        check("rst_wready", 32'(s_wready), 32'd0);
        check("rst_bvalid", 32'(s_bvalid), 32'd0);
        check("rst_arready", 32'(s_arready), 32'd1);
        check("rst_awready", 32'(s_awready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Preload word i = 0x1000_0000 + i through the write path.
        for (int l = 0; l < int'(DEPTH / 16); l++) begin
            for (int n = 0; n < 16; n++) begin
                wd[n] = 32'h1000_0000 + 32'(l * 16 + n);
                ws[n] = 4'hF;
            end
            wr_burst(32'(l * 64), 16, 1'(l % 2), l % 4);
        end

        rd_burst(32'h0000_0040, 1'b0, 1'b1, 16);
        rd_burst(32'h0000_0048, 1'b0, 1'b1, 16);

        for (int n = 0; n < 16; n++) begin
            wd[n] = 32'hA5A5_0000 + 32'(n);
            ws[n] = 4'hF;
        end
        wr_burst(32'h0000_0080, 16, 1'b0, 3);
        rd_burst(32'h0000_0080, 1'b1, 1'b0, 16);

        wd[0] = 32'h1234_5678; ws[0] = 4'hF;
        wr_burst(32'h0000_0100, 1, 1'b0, 0);
        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'h3;
        wr_burst(32'h0000_0100, 1, 1'b0, 1);
        rd_burst(32'h0000_0100, 1'b0, 1'b1, 16);

        // Same-cycle AR and AW: read first, AW held off until the burst is done.
        s_araddr  = 32'h0000_0140;
        s_awaddr  = 32'h0000_0204;
        s_arvalid = 1'b1;
        s_awvalid = 1'b1;
        #1;
        check("tie_arready", 32'(s_arready), 32'd1);
        check("tie_awready", 32'(s_awready), 32'd0);
        aw_leak = 0;
        rd_burst(32'h0000_0140, 1'b1, 1'b0, 16);
        check("aw_blocked", 32'(aw_leak), 32'd0);
        for (int n = 0; n < 20; n++) begin
            wd[n] = $urandom;
            ws[n] = 4'($urandom_range(0, 15));
        end
        wr_burst(32'h0000_0204, 20, 1'b1, 2);
        rd_burst(32'h0000_0200, 1'b1, 1'b0, 16);

        for (int it = 0; it < 40; it++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                for (int n = 0; n < 20; n++) begin
                    wd[n] = $urandom;
                    ws[n] = 4'($urandom_range(0, 15));
                end
                wr_burst(a, int'($urandom_range(1, 20)), 1'b1, int'($urandom_range(0, 3)));
            end else if ($urandom_range(0, 1) == 1) begin
                rd_burst(a, 1'b1, 1'b0, 16);
            end else begin
                rd_burst(a, 1'b0, 1'b1, 16);
            end
        end

        // Reset during beat 7 with rready toggling; contents must survive.
        rd_burst(32'h8000_0048, 1'b1, 1'b0, 7);
        rd_burst(32'h0000_0048, 1'b1, 1'b0, 16);
        rd_burst(32'h0000_0080, 1'b0, 1'b1, 16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
